// File: rtl/vector_alu_sequencer.sv
// Purpose : issues a whole-vector command to the vector ALU one element pair per cycle and gathers the results into a response vector.
// Latency : the response is valid L + ALU_latency + 1 cycles after the command is accepted, or 1 cycle after accept when L = 0.
// Backpr.  : accepts a command only in IDLE and holds the response until rsp_ready. It applies no backpressure to the ALU and receives none from it.
//
// Ports:
//   clk, rst                       clock and asynchronous active-high reset
//   cmd_*                          command: opcode, dtypes, length (clamped to MAX_ELEMENTS), operand vectors
//   alu_*  (out)                   opcode/dtypes (held from accept), element operands, issue strobe
//   alu_*  (in)                    element result, result strobe, overflow/underflow flags
//   rsp_*                          result vector, processed length, ORed flags, valid/ready
//   perf_elem_count                issued-element counter; live only when VECTOR_ALU_SEQ_PERF_EN is defined

package vector_alu_pkg;
    typedef enum logic [1:0] {
        DT_INT32 = 2'd0,
        DT_INT64 = 2'd1,
        DT_FP32  = 2'd2,
        DT_FP64  = 2'd3
    } data_type_e;
endpackage

module vector_alu_sequencer
    import vector_alu_pkg::*;
#(
    parameter int ELEMENT_WIDTH = 64,
    parameter int MAX_ELEMENTS  = 16,
    parameter int LEN_WIDTH     = $clog2(MAX_ELEMENTS + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [3:0]                              cmd_op,
    input  data_type_e                              cmd_src_dtype,
    input  data_type_e                              cmd_dst_dtype,
    input  logic [LEN_WIDTH-1:0]                    cmd_len,
    input  logic [MAX_ELEMENTS*ELEMENT_WIDTH-1:0]   cmd_src_a,
    input  logic [MAX_ELEMENTS*ELEMENT_WIDTH-1:0]   cmd_src_b,
    output logic [3:0]                              alu_operation,
    output data_type_e                              alu_src_dtype,
    output data_type_e                              alu_dst_dtype,
    output logic [ELEMENT_WIDTH-1:0]                alu_operand_a,
    output logic [ELEMENT_WIDTH-1:0]                alu_operand_b,
    output logic                                    alu_valid_in,
    input  logic [ELEMENT_WIDTH-1:0]                alu_result,
    input  logic                                    alu_valid_out,
    input  logic                                    alu_overflow,
    input  logic                                    alu_underflow,
    output logic                                    rsp_valid,
    input  logic                                    rsp_ready,
    output logic [MAX_ELEMENTS*ELEMENT_WIDTH-1:0]   rsp_data,
    output logic [LEN_WIDTH-1:0]                    rsp_len,
    output logic                                    rsp_overflow,
    output logic                                    rsp_underflow,
    output logic [31:0]                             perf_elem_count
);

    localparam int                   IDX_WIDTH = (MAX_ELEMENTS > 1) ? $clog2(MAX_ELEMENTS) : 1;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_ELEMENTS);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e                     state;
    state_e                     state_nxt;

    logic [3:0]                 op_q;
    data_type_e                 src_dt_q;
    data_type_e                 dst_dt_q;
    logic [ELEMENT_WIDTH-1:0]   src_a_q [MAX_ELEMENTS];
    logic [ELEMENT_WIDTH-1:0]   src_b_q [MAX_ELEMENTS];
    logic [ELEMENT_WIDTH-1:0]   rsp_mem [MAX_ELEMENTS];
    logic [LEN_WIDTH-1:0]       len_q;
    logic [LEN_WIDTH-1:0]       issue_idx;
    logic [LEN_WIDTH-1:0]       ret_idx;
    logic [LEN_WIDTH-1:0]       cmd_len_clamped;

    logic                       accept;
    logic                       capture;
    logic                       capture_last;
    logic                       issue_last;

    assign cmd_len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    assign accept          = cmd_valid && (state == S_IDLE);

    // Returns are taken only while a vector is in flight and only until
    // len of them have arrived; anything beyond that is dropped.
    assign capture      = alu_valid_out && ((state == S_ISSUE) || (state == S_DRAIN))
                          && (ret_idx < len_q);
    assign capture_last = capture && ((ret_idx + LEN_ONE) == len_q);
    assign issue_last   = (state == S_ISSUE) && ((issue_idx + LEN_ONE) == len_q);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (cmd_len_clamped == '0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A zero-latency ALU can complete the vector while still
                // issuing; completion is judged by returns, so it wins.
                if (capture_last) begin
                    state_nxt = S_RESP;
                end else if (issue_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (capture_last) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        cmd_ready     = 1'b0;
        alu_valid_in  = 1'b0;
        rsp_valid     = 1'b0;
        alu_operand_a = '0;
        alu_operand_b = '0;
        case (state)
            S_IDLE:  cmd_ready = 1'b1;
            S_ISSUE: begin
                alu_valid_in  = 1'b1;
                alu_operand_a = src_a_q[issue_idx[IDX_WIDTH-1:0]];
                alu_operand_b = src_b_q[issue_idx[IDX_WIDTH-1:0]];
            end
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Opcode and dtypes stay at the accepted values until the next accept,
    // so the ALU's registered opcode always matches its in-flight operands.
    assign alu_operation = op_q;
    assign alu_src_dtype = src_dt_q;
    assign alu_dst_dtype = dst_dt_q;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= '0;
            src_dt_q      <= DT_INT32;
            dst_dt_q      <= DT_INT32;
            len_q         <= '0;
            issue_idx     <= '0;
            ret_idx       <= '0;
            rsp_len       <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            for (int i = 0; i < MAX_ELEMENTS; i++) begin
                src_a_q[i] <= '0;
                src_b_q[i] <= '0;
                rsp_mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                op_q          <= cmd_op;
                src_dt_q      <= cmd_src_dtype;
                dst_dt_q      <= cmd_dst_dtype;
                len_q         <= cmd_len_clamped;
                rsp_len       <= cmd_len_clamped;
                issue_idx     <= '0;
                ret_idx       <= '0;
                rsp_overflow  <= 1'b0;
                rsp_underflow <= 1'b0;
                for (int i = 0; i < MAX_ELEMENTS; i++) begin
                    src_a_q[i] <= cmd_src_a[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
                    src_b_q[i] <= cmd_src_b[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
                    rsp_mem[i] <= '0;
                end
            end
            if (state == S_ISSUE) begin
                issue_idx <= issue_idx + LEN_ONE;
            end
            if (capture) begin
                rsp_mem[ret_idx[IDX_WIDTH-1:0]] <= alu_result;
                ret_idx                         <= ret_idx + LEN_ONE;
                rsp_overflow                    <= rsp_overflow  | alu_overflow;
                rsp_underflow                   <= rsp_underflow | alu_underflow;
            end
        end
    end

    for (genvar g = 0; g < MAX_ELEMENTS; g++) begin : g_rsp_pack
        assign rsp_data[g*ELEMENT_WIDTH +: ELEMENT_WIDTH] = rsp_mem[g];
    end

    // ---------------- performance counter ----------------
`ifdef VECTOR_ALU_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (alu_valid_in) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_elem_count = perf_q;
`else
    assign perf_elem_count = '0;
`endif

endmodule
